// File: rtl/pe_pkg.sv
// Shared definitions for the MAC processing element: FSM encoding,
// mode constants and the default accumulator width derivation.
package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } pe_state_e;

  localparam logic MODE_PASS  = 1'b0;
  localparam logic MODE_ACCUM = 1'b1;

  // Four guard bits above the full product width by default.
  function automatic int acc_width_default(input int data_width);
    return 2 * data_width + 4;
  endfunction

endpackage

// File: rtl/sat_add.sv
// Signed saturating adder: clamps to the W-bit signed range and flags it.
module sat_add #(
  parameter int W = 12
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                clamp
);

  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic [W:0] wide;

  assign wide = {a[W-1], a} + {b[W-1], b};

  // Overflow shows as disagreement between the guard bit and the sign bit.
  always_comb begin
    clamp = wide[W] ^ wide[W-1];
    if (!clamp) begin
      sum = wide[W-1:0];
    end else if (wide[W]) begin
      sum = MIN_VAL;
    end else begin
      sum = MAX_VAL;
    end
  end

endmodule

// File: rtl/mac_pe.sv
// Systolic MAC processing element: PASS mode adds the local product into a
// flowing partial sum; ACCUM mode keeps an output-stationary accumulator
// and drains its result onto the sum chain when the chain is free.
module mac_pe
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = acc_width_default(DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode,
  input  logic signed [DATA_WIDTH-1:0] in_left,
  input  logic signed [DATA_WIDTH-1:0] in_top,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic signed [ACC_WIDTH-1:0]  in_sum,
  input  logic                         in_sum_valid,
  output logic signed [DATA_WIDTH-1:0] out_right,
  output logic signed [DATA_WIDTH-1:0] out_bot,
  output logic                         out_valid,
  output logic                         out_last,
  output logic signed [ACC_WIDTH-1:0]  out_sum,
  output logic                         out_sum_valid,
  output logic                         sat_flag,
  output logic                         overrun
);

  localparam int PW = 2 * DATA_WIDTH;

  pe_state_e state_q, state_d;

  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]  out_sum_q, out_sum_d;
  logic                         out_sum_valid_q, out_sum_valid_d;
  logic signed [DATA_WIDTH-1:0] out_right_q, out_right_d;
  logic signed [DATA_WIDTH-1:0] out_bot_q, out_bot_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic                         sat_q, sat_d;
  logic                         overrun_q, overrun_d;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] in_sum_eff;
  logic signed [ACC_WIDTH-1:0] pass_sum, acc_sum;
  logic                        pass_clamp, acc_clamp;
  logic                        finish_pair;

  assign prod       = PW'(in_left) * PW'(in_top);
  assign prod_ext   = ACC_WIDTH'(prod);
  assign in_sum_eff = in_sum_valid ? in_sum : '0;
  assign finish_pair = in_valid && in_last;

  // Sum-chain path: upstream partial sum plus the local product.
  sat_add #(.W(ACC_WIDTH)) u_pass_add (
    .a     (in_sum_eff),
    .b     (prod_ext),
    .sum   (pass_sum),
    .clamp (pass_clamp)
  );

  // Accumulator path: running dot product plus the local product.
  sat_add #(.W(ACC_WIDTH)) u_acc_add (
    .a     (acc_q),
    .b     (prod_ext),
    .sum   (acc_sum),
    .clamp (acc_clamp)
  );

  // State and datapath registers; reset drops everything including a held result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      acc_q           <= '0;
      out_sum_q       <= '0;
      out_sum_valid_q <= 1'b0;
      out_right_q     <= '0;
      out_bot_q       <= '0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      sat_q           <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      out_sum_q       <= out_sum_d;
      out_sum_valid_q <= out_sum_valid_d;
      out_right_q     <= out_right_d;
      out_bot_q       <= out_bot_d;
      out_valid_q     <= out_valid_d;
      out_last_q      <= out_last_d;
      sat_q           <= sat_d;
      overrun_q       <= overrun_d;
    end
  end

  // Next state: mode only matters in IDLE; a final pair skips HOLD when the chain is free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_ACCUM && in_valid) begin
          if (in_last) state_d = in_sum_valid ? ST_HOLD : ST_IDLE;
          else         state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (finish_pair) state_d = in_sum_valid ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (!in_sum_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: operand forwarding, accumulation, emission and flags.
  always_comb begin
    out_right_d     = in_valid ? in_left : out_right_q;
    out_bot_d       = in_valid ? in_top  : out_bot_q;
    out_last_d      = in_valid ? in_last : out_last_q;
    out_valid_d     = in_valid;
    acc_d           = acc_q;
    out_sum_d       = in_sum;
    out_sum_valid_d = in_sum_valid;
    sat_d           = sat_q;
    overrun_d       = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_PASS) begin
          if (in_valid) begin
            out_sum_d       = pass_sum;
            out_sum_valid_d = 1'b1;
            sat_d           = sat_q | pass_clamp;
          end
        end else if (in_valid) begin
          acc_d = prod_ext;
          sat_d = 1'b0;
          if (in_last && !in_sum_valid) begin
            out_sum_d       = prod_ext;
            out_sum_valid_d = 1'b1;
          end
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          acc_d = acc_sum;
          sat_d = sat_q | acc_clamp;
          if (in_last && !in_sum_valid) begin
            out_sum_d       = acc_sum;
            out_sum_valid_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (in_valid) overrun_d = 1'b1;
        if (!in_sum_valid) begin
          out_sum_d       = acc_q;
          out_sum_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out_sum       = out_sum_q;
  assign out_sum_valid = out_sum_valid_q;
  assign out_right     = out_right_q;
  assign out_bot       = out_bot_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign sat_flag      = sat_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_mac_pe.sv
// Directed bench for mac_pe: a 12-bit accumulator instance for the main
// function and an 8-bit instance sharing the same stimulus for saturation.
module tb_mac_pe;

  logic              clk = 1'b0;
  logic              reset;
  logic              mode;
  logic signed [3:0] in_left, in_top;
  logic              in_valid, in_last;
  logic signed [11:0] in_sum;
  logic              in_sum_valid;
  logic signed [7:0] in_sum8;

  logic signed [3:0]  out_right, out_bot;
  logic               out_valid, out_last;
  logic signed [11:0] out_sum;
  logic               out_sum_valid, sat_flag, overrun;

  logic signed [3:0]  out_right8, out_bot8;
  logic               out_valid8, out_last8;
  logic signed [7:0]  out_sum8;
  logic               out_sum_valid8, sat_flag8, overrun8;

  int checks = 0;
  int errors = 0;

  assign in_sum8 = in_sum[7:0];

  always #5 clk = ~clk;

  mac_pe #(.DATA_WIDTH(4), .ACC_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_left(in_left), .in_top(in_top), .in_valid(in_valid), .in_last(in_last),
    .in_sum(in_sum), .in_sum_valid(in_sum_valid),
    .out_right(out_right), .out_bot(out_bot), .out_valid(out_valid), .out_last(out_last),
    .out_sum(out_sum), .out_sum_valid(out_sum_valid),
    .sat_flag(sat_flag), .overrun(overrun)
  );

  mac_pe #(.DATA_WIDTH(4), .ACC_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .mode(mode),
    .in_left(in_left), .in_top(in_top), .in_valid(in_valid), .in_last(in_last),
    .in_sum(in_sum8), .in_sum_valid(in_sum_valid),
    .out_right(out_right8), .out_bot(out_bot8), .out_valid(out_valid8), .out_last(out_last8),
    .out_sum(out_sum8), .out_sum_valid(out_sum_valid8),
    .sat_flag(sat_flag8), .overrun(overrun8)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic lst, input int l, input int t,
                       input logic sv, input int s);
    in_valid     = v;
    in_last      = lst;
    in_left      = 4'(l);
    in_top       = 4'(t);
    in_sum_valid = sv;
    in_sum       = 12'(s);
  endtask

  task automatic tick(input string what);
    @(posedge clk);
    #1;
    $display("t=%0t %s: out_sum=%0d osv=%0b right=%0d bot=%0d ov=%0b sat=%0b ovr=%0b",
             $time, what, out_sum, out_sum_valid, out_right, out_bot,
             out_valid, sat_flag, overrun);
  endtask

  initial begin
    reset = 1'b1;
    mode  = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    check("rst_out_sum", out_sum, 0);
    check("rst_osv", out_sum_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b0;

    // PASS mode
    drive(1, 0, 3, -2, 1, 10);        tick("pass 3*-2+10");
    check("pass_sum", out_sum, 4);
    check("pass_osv", out_sum_valid, 1);
    check("pass_right", out_right, 3);
    check("pass_bot", out_bot, -2);
    check("pass_ovalid", out_valid, 1);
    drive(0, 0, 0, 0, 1, -5);         tick("pass through -5");
    check("thru_sum", out_sum, -5);
    check("thru_hold_right", out_right, 3);
    check("thru_ovalid", out_valid, 0);
    drive(1, 0, 2, -4, 0, 500);       tick("pass invalid sum");
    check("nosum_sum", out_sum, -8);
    drive(1, 0, -3, -3, 1, 2040);     tick("pass sat high");
    check("sat_hi_sum", out_sum, 2047);
    check("sat_hi_flag", sat_flag, 1);
    drive(1, 0, 3, -3, 1, -2048);     tick("pass sat low");
    check("sat_lo_sum", out_sum, -2048);

    // ACCUM: 6 - 4 + 25 = 27, mode change mid-accumulation ignored
    mode = 1'b1;
    drive(1, 0, 2, 3, 0, 0);          tick("acc (2,3)");
    check("acc_start_osv", out_sum_valid, 0);
    check("acc_start_sat_clr", sat_flag, 0);
    mode = 1'b0;
    drive(1, 0, -1, 4, 0, 0);         tick("acc (-1,4)");
    drive(1, 1, 5, 5, 0, 0);          tick("acc (5,5) last");
    mode = 1'b1;
    check("acc_result", out_sum, 27);
    check("acc_result_osv", out_sum_valid, 1);
    check("acc_out_last", out_last, 1);
    drive(0, 0, 0, 0, 0, 0);          tick("acc idle");
    check("acc_idle_osv", out_sum_valid, 0);

    // Collision: chain busy for two cycles from HOLD entry
    drive(1, 0, 2, 3, 0, 0);          tick("col (2,3)");
    drive(1, 0, -1, 4, 0, 0);         tick("col (-1,4)");
    drive(1, 1, 5, 5, 1, 7);          tick("col (5,5) last, sum 7");
    check("col_first7", out_sum, 7);
    drive(0, 0, 0, 0, 1, 7);          tick("col sum 7");
    check("col_second7", out_sum, 7);
    check("col_no_overrun", overrun, 0);
    drive(0, 0, 0, 0, 0, 0);          tick("col drain");
    check("col_result", out_sum, 27);
    check("col_result_osv", out_sum_valid, 1);

    // Overrun: operand arrives while HOLD is blocked
    drive(1, 1, 1, 1, 1, 7);          tick("ovr (1,1) last, sum 7");
    check("ovr_hold7", out_sum, 7);
    drive(1, 0, 6, -7, 1, 7);         tick("ovr blocked operand");
    check("ovr_flag", overrun, 1);
    check("ovr_fwd_right", out_right, 6);
    check("ovr_fwd_bot", out_bot, -7);
    drive(0, 0, 0, 0, 0, 0);          tick("ovr drain");
    check("ovr_result", out_sum, 1);
    drive(0, 0, 0, 0, 0, 0);          tick("ovr idle");
    check("ovr_sticky", overrun, 1);

    // Asynchronous reset mid-accumulation
    drive(1, 0, 2, 3, 0, 0);          tick("rst (2,3)");
    drive(1, 0, 1, 2, 0, 0);          tick("rst (1,2)");
    #1 reset = 1'b1;
    #1;
    check("arst_right", out_right, 0);
    check("arst_bot", out_bot, 0);
    check("arst_ovalid", out_valid, 0);
    check("arst_overrun", overrun, 0);
    check("arst_sum", out_sum, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 1, 1, 1, 0, 0);          tick("post-rst (1,1) last");
    check("post_rst_sum", out_sum, 1);
    check("post_rst_osv", out_sum_valid, 1);

    // Emission coincides with a new first operand: operand dropped
    drive(1, 1, 1, 1, 1, 9);          tick("coll (1,1) last, sum 9");
    check("coll_hold9", out_sum, 9);
    drive(1, 0, 2, 2, 0, 0);          tick("coll emit + operand");
    check("coll_emit", out_sum, 1);
    check("coll_overrun", overrun, 1);
    drive(1, 1, 1, 1, 0, 0);          tick("coll (1,1) last");
    check("coll_dropped", out_sum, 1);

    // Saturation on the 8-bit accumulator: 64+64+64 clamps to 127
    drive(1, 0, -8, -8, 0, 0);        tick("sat8 #1");
    check("sat8_none", sat_flag8, 0);
    drive(1, 0, -8, -8, 0, 0);        tick("sat8 #2");
    check("sat8_set", sat_flag8, 1);
    drive(1, 1, -8, -8, 0, 0);        tick("sat8 #3 last");
    check("sat8_result", out_sum8, 127);
    check("sat8_osv", out_sum_valid8, 1);
    check("sat8_flag", sat_flag8, 1);
    drive(1, 0, 1, 1, 0, 0);          tick("sat8 new start");
    check("sat8_cleared", sat_flag8, 0);
    drive(1, 1, 1, 1, 0, 0);          tick("sat8 (1,1) last");
    check("sat8_small", out_sum8, 2);

    drive(0, 0, 0, 0, 0, 0);
    tick("end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
